// File: rtl/sd_rx_dma_ctrl_pkg.sv
// Shared definitions for the SD receive DMA path: state encoding,
// DMA word size and default counter widths.
package sd_rx_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } dma_state_t;

    // Bytes moved per bus write (one 32-bit word).
    localparam int DMA_WORD_BYTES = 4;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TMO_W = 16;

endpackage

// File: rtl/sd_dma_tmo_cnt.sv
// Starvation timeout counter: loadable limit, clear, enable and a
// combinational hit flag that fires in the cycle that would bring the
// count up to the limit. A zero limit never hits. The count saturates.
module sd_dma_tmo_cnt
    import sd_rx_dma_ctrl_pkg::*;
#(
    parameter int W = DEF_TMO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] limit,
    input  logic         clr,
    input  logic         en,
    output logic         hit
);

    logic [W-1:0] limit_q;
    logic [W-1:0] count_q;
    logic [W-1:0] count_inc;

    assign count_inc = count_q + 1'b1;
    assign hit       = en && (limit_q != '0) && (count_inc == limit_q);

    // Limit register and saturating cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q <= '0;
            count_q <= '0;
        end else begin
            if (load) begin
                limit_q <= limit;
            end
            if (clr) begin
                count_q <= '0;
            end else if (en && (count_q != '1)) begin
                count_q <= count_inc;
            end
        end
    end

endmodule

// File: rtl/sd_rx_dma_ctrl.sv
// Wishbone-master DMA sequencer draining the SD RX FIFO into memory.
// Handshakes: the FIFO pops when fifo_rd_o is high at a clock edge and
// fifo_q_i is valid whenever fifo_empty_i is low (show-ahead); a bus write
// holds cyc/stb/we/adr/dat stable until the slave returns ack or err.
module sd_rx_dma_ctrl
    import sd_rx_dma_ctrl_pkg::*;
#(
    parameter int ADR_W = 32,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ADR_W-1:0] dst_adr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic [31:0]      fifo_q_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic [ADR_W-1:0] m_wb_adr_o,
    output logic [31:0]      m_wb_dat_o,
    output logic [3:0]       m_wb_sel_o,
    output logic             m_wb_we_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             tmo_o,
    output logic             abort_o,
    output logic [CNT_W-1:0] words_left_o,
    output dma_state_t       dbg_state_o
);

    dma_state_t       state_q;
    logic [ADR_W-1:0] adr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      dat_q;
    logic             bus_q;
    logic [3:0]       sel_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             tmo_q;
    logic             abort_q;

    logic tmo_load;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_hit;

    // Pop strobe: at most one per word, only while waiting for data.
    assign fifo_rd_o = (state_q == ST_WAIT) && !fifo_empty_i;

    assign tmo_load = (state_q == ST_IDLE) && start_i;
    assign tmo_clr  = tmo_load || fifo_rd_o;
    assign tmo_en   = (state_q == ST_WAIT) && fifo_empty_i && !abort_i;

    sd_dma_tmo_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .load  (tmo_load),
        .limit (timeout_i),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .hit   (tmo_hit)
    );

    // Transfer sequencer with registered bus and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            bus_q   <= 1'b0;
            sel_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            sel_q   <= 4'hF;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        adr_q   <= dst_adr_i & ~ADR_W'(3);
                        cnt_q   <= word_cnt_i;
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (word_cnt_i == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!fifo_empty_i) begin
                        dat_q   <= fifo_q_i;
                        bus_q   <= 1'b1;
                        state_q <= ST_WRITE;
                    end else if (tmo_hit) begin
                        tmo_q   <= 1'b1;
                        state_q <= ST_FAIL;
                    end
                end
                ST_WRITE: begin
                    if (abort_i) begin
                        bus_q   <= 1'b0;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (m_wb_err_i) begin
                        bus_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_FAIL;
                    end else if (m_wb_ack_i) begin
                        bus_q   <= 1'b0;
                        adr_q   <= adr_q + ADR_W'(DMA_WORD_BYTES);
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= (cnt_q == CNT_W'(1)) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (abort_i) begin
                        abort_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    bus_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    bus_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_wb_adr_o   = adr_q;
    assign m_wb_dat_o   = dat_q;
    assign m_wb_sel_o   = sel_q;
    assign m_wb_we_o    = bus_q;
    assign m_wb_cyc_o   = bus_q;
    assign m_wb_stb_o   = bus_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign tmo_o        = tmo_q;
    assign abort_o      = abort_q;
    assign words_left_o = cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sd_rx_dma_ctrl.sv
// Directed bench for sd_rx_dma_ctrl: FIFO and Wishbone slave models,
// write log checked against an expected queue, immediate assertions.
module tb_sd_rx_dma_ctrl;
    import sd_rx_dma_ctrl_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] dst_adr_i = '0;
    logic [15:0] word_cnt_i = '0;
    logic [15:0] timeout_i = '0;
    logic [31:0] fifo_q_i;
    logic        fifo_empty_i;
    logic        fifo_rd_o;
    logic [31:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic        m_wb_ack_i, m_wb_err_i;
    logic        busy_o, done_o, err_o, tmo_o, abort_o;
    logic [15:0] words_left_o;
    dma_state_t  dbg_state_o;

    always #5 clk = ~clk;

    sd_rx_dma_ctrl #(.ADR_W(32), .CNT_W(16), .TMO_W(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .dst_adr_i    (dst_adr_i),
        .word_cnt_i   (word_cnt_i),
        .timeout_i    (timeout_i),
        .fifo_q_i     (fifo_q_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .m_wb_adr_o   (m_wb_adr_o),
        .m_wb_dat_o   (m_wb_dat_o),
        .m_wb_sel_o   (m_wb_sel_o),
        .m_wb_we_o    (m_wb_we_o),
        .m_wb_cyc_o   (m_wb_cyc_o),
        .m_wb_stb_o   (m_wb_stb_o),
        .m_wb_ack_i   (m_wb_ack_i),
        .m_wb_err_i   (m_wb_err_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .tmo_o        (tmo_o),
        .abort_o      (abort_o),
        .words_left_o (words_left_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- FIFO and slave models ----------------
    logic [31:0] fifo_mem [0:15];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    int          wr_seen = 0;
    int          err_on_write = 0;
    logic        slave_stall = 1'b0;

    assign fifo_empty_i = (rd_ptr == wr_ptr);
    assign fifo_q_i     = fifo_mem[rd_ptr[3:0]];
    assign m_wb_err_i   = m_wb_stb_o && ((wr_seen + 1) == err_on_write);
    assign m_wb_ack_i   = m_wb_stb_o && !slave_stall && !m_wb_err_i;

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    always @(posedge clk) begin
        if (fifo_rd_o) begin
            rd_ptr <= rd_ptr + 1;
            rd_cnt++;
        end
        if (m_wb_cyc_o && m_wb_stb_o && (m_wb_ack_i || m_wb_err_i)) begin
            wr_seen <= wr_seen + 1;
        end
        if (m_wb_cyc_o && m_wb_stb_o && m_wb_ack_i) begin
            obs_q.push_back({m_wb_adr_o, m_wb_dat_o});
        end
        if (done_o) done_cnt++;
        if (abort_o) abort_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic do_start(input logic [31:0] adr, input logic [15:0] cnt, input logic [15:0] tmo);
        dst_adr_i  = adr;
        word_cnt_i = cnt;
        timeout_i  = tmo;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    // which: 0 = done_o, 1 = tmo_o, 2 = err_o; n = ticks taken or -1.
    task automatic wait_for(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((which == 0 && done_o) || (which == 1 && tmo_o) || (which == 2 && err_o)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;

        // Reset state
        tick(); tick();
        check("rst_sel", m_wb_sel_o, 4'h0);
        check("rst_cyc", m_wb_cyc_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_adr", m_wb_adr_o, 32'h0);
        check("rst_left", words_left_o, 16'h0);
        check("rst_state", dbg_state_o, ST_IDLE);
        rst = 1'b0;
        tick();
        check("sel_after_rst", m_wb_sel_o, 4'hF);

        // Basic transfer, 4 words, zero-wait slave
        push_word(32'h11111111); push_word(32'h22222222);
        push_word(32'h33333333); push_word(32'h44444444);
        do_start(32'h1000, 16'd4, 16'd0);
        check("t1_busy", busy_o, 1'b1);
        check("t1_left", words_left_o, 16'd4);
        check("t1_pop_c1", fifo_rd_o, 1'b1);
        tick();
        check("t1_stb_c2", m_wb_stb_o, 1'b1);
        check("t1_we", m_wb_we_o, 1'b1);
        check("t1_adr0", m_wb_adr_o, 32'h1000);
        check("t1_dat0", m_wb_dat_o, 32'h11111111);
        wait_for(0, 20, n);
        check("t1_done_lat", 64'(n), 64'd8);
        check("t1_busy_end", busy_o, 1'b0);
        tick();
        check("t1_done_pulse", done_o, 1'b0);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd4);
        exp_q.push_back({32'h1000, 32'h11111111});
        exp_q.push_back({32'h1004, 32'h22222222});
        exp_q.push_back({32'h1008, 32'h33333333});
        exp_q.push_back({32'h100C, 32'h44444444});
        check_writes("t1_wr");

        // Starvation and timeout
        push_word(32'hAAAA0001);
        do_start(32'h2000, 16'd2, 16'd10);
        wait_for(1, 40, n);
        check("t2_tmo_lat", 64'(n), 64'd12);
        check("t2_busy_hold", busy_o, 1'b1);
        check("t2_left", words_left_o, 16'd1);
        tick();
        check("t2_busy_drop", busy_o, 1'b0);
        check("t2_tmo_sticky", tmo_o, 1'b1);
        check("t2_no_done", 64'(done_cnt), 64'd1);
        exp_q.push_back({32'h2000, 32'hAAAA0001});
        check_writes("t2_wr");

        // Bus error on 2nd write of 3
        push_word(32'hB0000001); push_word(32'hB0000002); push_word(32'hB0000003);
        wr_seen = 0;
        err_on_write = 2;
        do_start(32'h3000, 16'd3, 16'd0);
        wait_for(2, 20, n);
        check("t3_err_lat", 64'(n), 64'd4);
        check("t3_cyc_low", m_wb_cyc_o, 1'b0);
        check("t3_left", words_left_o, 16'd2);
        tick();
        check("t3_busy_drop", busy_o, 1'b0);
        check("t3_no_done", 64'(done_cnt), 64'd1);
        exp_q.push_back({32'h3000, 32'hB0000001});
        check_writes("t3_wr");
        err_on_write = 0;
        do_start(32'h3101, 16'd1, 16'd0);
        check("t3_err_clr", err_o, 1'b0);
        wait_for(0, 20, n);
        check("t3b_done_lat", 64'(n), 64'd3);
        exp_q.push_back({32'h3100, 32'hB0000003});
        check_writes("t3b_wr");

        // Abort during a stalled write
        push_word(32'hC0DE0001);
        slave_stall = 1'b1;
        do_start(32'h4000, 16'd1, 16'd0);
        tick(); tick(); tick();
        check("t4_stall_stb", m_wb_stb_o, 1'b1);
        check("t4_stall_adr", m_wb_adr_o, 32'h4000);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_cyc", m_wb_cyc_o, 1'b0);
        check("t4_stb", m_wb_stb_o, 1'b0);
        check("t4_abort", abort_o, 1'b1);
        check("t4_busy", busy_o, 1'b0);
        check("t4_state", dbg_state_o, ST_IDLE);
        tick();
        check("t4_abort_pulse", abort_o, 1'b0);
        slave_stall = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_idle_abort", abort_o, 1'b0);
        check("t4_idle_busy", busy_o, 1'b0);
        check_writes("t4_wr");

        // Zero count
        do_start(32'h5000, 16'd0, 16'd0);
        check("t5_done_c1", done_o, 1'b0);
        tick();
        check("t5_done_c2", done_o, 1'b1);
        check("t5_cyc", m_wb_cyc_o, 1'b0);
        check_writes("t5_wr");

        // Address wrap and ignored start while busy
        push_word(32'hD0000001); push_word(32'hD0000002);
        do_start(32'hFFFFFFFF, 16'd2, 16'd0);
        dst_adr_i = 32'h9000;
        word_cnt_i = 16'd7;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t6_adr0", m_wb_adr_o, 32'hFFFFFFFC);
        wait_for(0, 20, n);
        check("t6_done_lat", 64'(n), 64'd4);
        check("t6_left", words_left_o, 16'd0);
        exp_q.push_back({32'hFFFFFFFC, 32'hD0000001});
        exp_q.push_back({32'h00000000, 32'hD0000002});
        check_writes("t6_wr");

        // Synchronous reset mid-transfer
        push_word(32'hE0000001);
        slave_stall = 1'b1;
        do_start(32'h6000, 16'd1, 16'd0);
        tick();
        check("t7_stb", m_wb_stb_o, 1'b1);
        rst = 1'b1;
        tick();
        check("t7_cyc", m_wb_cyc_o, 1'b0);
        check("t7_busy", busy_o, 1'b0);
        rst = 1'b0;
        slave_stall = 1'b0;
        tick(); tick();
        check("t7_done_cnt", 64'(done_cnt), 64'd4);
        check("t7_abort_cnt", 64'(abort_cnt), 64'd1);
        check("t7_rd_cnt", 64'(rd_cnt), 64'd12);
        check_writes("t7_wr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_rx_dma_ctrl.md
# sd_rx_dma_ctrl

Wishbone-master DMA sequencer that drains the SD receive FIFO (32-bit show-ahead words, `rd`/`empty` handshake) into system memory. It sits between the RX FIFO read port and the host bus. It is programmed per transfer with destination address, word count and timeout, and reports done, bus error, timeout and abort to the SD controller register block.

## Interface
Parameters:
- `ADR_W`, 32: Wishbone address width.
- `CNT_W`, 16: width of the transfer word count.
- `TMO_W`, 16: width of the FIFO-starvation timeout.

Ports:
- `wb_clk_i` in 1: single clock; the FIFO read side runs on this clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: start pulse, accepted only in IDLE.
- `abort_i` in 1: abort request, level-sampled.
- `dst_adr_i` in ADR_W: byte start address, word aligned; bits [1:0] are ignored.
- `word_cnt_i` in CNT_W: number of 32-bit words to transfer.
- `timeout_i` in TMO_W: starvation limit in cycles; 0 disables the timeout.
- `fifo_q_i` in 32: FIFO head word.
- `fifo_empty_i` in 1: FIFO empty.
- `fifo_rd_o` out 1: one-cycle pop strobe.
- `m_wb_adr_o` out ADR_W, `m_wb_dat_o` out 32, `m_wb_sel_o` out 4 (constant 4'hF), `m_wb_we_o` out 1, `m_wb_cyc_o` out 1, `m_wb_stb_o` out 1.
- `m_wb_ack_i` in 1, `m_wb_err_i` in 1.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse on normal completion.
- `err_o` out 1: sticky bus-error flag.
- `tmo_o` out 1: sticky timeout flag.
- `abort_o` out 1: one-cycle pulse when an abort is taken.
- `words_left_o` out CNT_W: remaining word count.

## Operation
- States: IDLE, WAIT, WRITE, DONE, FAIL.
- IDLE
  - On `start_i`: latch address (bits [1:0] forced to 0) into `adr_q`, `word_cnt_i` into `cnt_q`, and `timeout_i`.
  - Clear `err_o` and `tmo_o`; clear the timeout counter.
  - Go to WAIT, or to DONE if `word_cnt_i` == 0.
- WAIT
  - If `!fifo_empty_i`: capture `fifo_q_i` into `dat_q`, pulse `fifo_rd_o`, clear the timeout counter, go to WRITE.
  - Otherwise increment the timeout counter. If the limit is nonzero and the counter reaches it, set `tmo_o` and go to FAIL.
- WRITE
  - `cyc`, `stb` and `we` are high. `adr` = `adr_q`, `dat` = `dat_q`, both stable until ack.
  - On `m_wb_ack_i`: `adr_q` += 4 (wraps modulo 2^ADR_W), `cnt_q` -= 1. Go to DONE if the new count is 0, else to WAIT.
  - On `m_wb_err_i`: set `err_o`, go to FAIL. The word is lost and the count is not decremented.
  - If ack and err arrive together, err wins.
- DONE: pulse `done_o`, go to IDLE.
- FAIL: all bus outputs low, go to IDLE. No `done_o`.
- Abort
  - `abort_i` in WAIT, WRITE or DONE takes priority over every other transition.
  - `cyc`/`stb` drop in the next cycle, `abort_o` pulses, the state goes to IDLE, and `done_o` is suppressed.
  - A word already popped but not acked is discarded.
  - `abort_i` in IDLE has no effect.
- `start_i` while busy is ignored.
- `words_left_o` = `cnt_q`.

## Timing
- Reset values: state IDLE; `adr_q`, `dat_q`, `cnt_q` and the timeout counter all 0. All outputs 0, including `m_wb_sel_o`, which then stays 4'hF after reset.
- All outputs are registered; `fifo_rd_o` is decoded from the registered state plus `fifo_empty_i`.
- Start to first `stb`: 2 cycles when the FIFO is non-empty (start at cycle 0, pop at cycle 1, `stb` at cycle 2).
- Throughput is 2 cycles per word plus slave wait states; at most one `fifo_rd_o` per word.
- `done_o` asserts the cycle after the final ack; `busy_o` falls in the same cycle as `done_o`.
- Timeout fires after exactly `timeout_i` consecutive empty cycles in WAIT. `tmo_o` is set the next cycle, and `busy_o` drops one cycle later.
- Synchronous reset mid-transfer drops `cyc`/`stb` the next cycle; no `done_o` or `abort_o`.

## Structure
- Shared package / `SD_defines.v`:
  - state encoding (3-bit localparams);
  - DMA word-size constant (4);
  - default `CNT_W` and `TMO_W`.
- One sub-module, `sd_dma_tmo_cnt`: a loadable saturating counter with clear, enable and `hit` output, reusable by the TX DMA path.
- Everything else is flat in `sd_rx_dma_ctrl`.

## Test plan
- Basic transfer:
  - Stimulus: FIFO preloaded with 4 words 0x11111111..0x44444444; start with `dst`=0x1000, cnt=4; zero-wait slave.
  - Response: writes to 0x1000/4/8/C with matching data; exactly 4 `fifo_rd_o` pulses; `done_o` 1 cycle after the 4th ack.
- Starvation and timeout:
  - Stimulus: cnt=2, one word available, `timeout_i`=10.
  - Response: one write; `tmo_o`=1 after 10 empty cycles; no `done_o`; `words_left_o`=1.
- Bus error:
  - Stimulus: `m_wb_err_i` on the 2nd write of 3.
  - Response: `err_o`=1, `cyc` low the next cycle, `words_left_o`=2, no `done_o`; a new start clears `err_o`.
- Abort and zero count:
  - Stimulus: `abort_i` during WRITE with the slave stalled.
  - Response: `cyc`/`stb` low next cycle, `abort_o` pulse, IDLE.
  - Stimulus: start with cnt=0.
  - Response: `done_o` 2 cycles after start, no bus cycle.
- Wrap and ignored start:
  - Stimulus: `dst`=0xFFFFFFFC, cnt=2; assert `start_i` while busy.
  - Response: second address is 0x00000000; the busy start has no effect.
